// File: rtl/simon_pkg.sv
// Shared Simon Says types: playback/check FSM states, sequence geometry, colour decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int MAX_LEN = 16;
    localparam int COLOR_W = 2;

    function automatic logic [3:0] color_onehot(input logic [COLOR_W-1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Interval timer: counts enabled cycles from 0, flags when the count equals limit.
// Latency: tc is combinational from the registered count; clr/en take effect next edge.
// Backpressure: none; en simply holds the count when low.
module tick_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/seq_player.sv
// Simon Says playback: latches a packed colour sequence and shows it entry by entry on led.
// Latency: first colour on led one cycle after start is taken; done L*(ON+OFF) cycles after start.
// Backpressure: none; start is ignored outside IDLE, abort wins over everything.
module seq_player #(
    parameter int ON_CYCLES  = 3,
    parameter int OFF_CYCLES = 2,
    parameter int MAX_LEN    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  level,
    input  logic [31:0] seq_in,
    output logic [3:0]  led,
    output logic [3:0]  idx,
    output logic        busy,
    output logic        done
);
    import simon_pkg::*;

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] ON_LIM       = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LIM      = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST_LIM = CW'((OFF_CYCLES > 1) ? OFF_CYCLES - 2 : 0);
    localparam logic [4:0]    MAX_LVL      = 5'(MAX_LEN);

    state_t        state_q, state_d;
    logic [31:0]   seq_q, seq_d;
    logic [4:0]    len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic          tick_clr, tick_en, tick_tc;
    logic [CW-1:0] tick_lim;
    logic [4:0]    lvl_clamp;
    logic          last;
    logic [3:0]    led_d;
    logic          busy_d, done_d;

    assign lvl_clamp = (level > MAX_LVL) ? MAX_LVL : level;
    assign last      = ({1'b0, idx_q} == (len_q - 5'd1));

    // Outputs trail the state by one register, so DONE doubles as the final blank
    // cycle: the last gap leaves OFF one cycle early to keep the entry period exact.
    assign tick_lim = (state_q == ST_OFF) ? (last ? OFF_LAST_LIM : OFF_LIM) : ON_LIM;

    tick_counter #(.W(CW)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .limit (tick_lim),
        .tc    (tick_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tick_clr = 1'b0;
        tick_en  = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            tick_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (lvl_clamp != 5'd0) begin
                            seq_d    = seq_in;
                            len_d    = lvl_clamp;
                            idx_d    = '0;
                            tick_clr = 1'b1;
                            state_d  = ST_ON;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_ON: begin
                    tick_en = 1'b1;
                    if (tick_tc) begin
                        tick_clr = 1'b1;
                        state_d  = (last && OFF_CYCLES == 1) ? ST_DONE : ST_OFF;
                    end
                end
                ST_OFF: begin
                    tick_en = 1'b1;
                    if (tick_tc) begin
                        tick_clr = 1'b1;
                        if (last) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_ON;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (!abort) begin
            busy_d = (state_q != ST_IDLE);
            done_d = (state_q == ST_DONE);
            if (state_q == ST_ON) begin
                led_d = color_onehot(seq_q[{idx_q, 1'b0} +: COLOR_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led  <= '0;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            led  <= led_d;
            idx  <= idx_q;
            busy <= busy_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with ON=3, OFF=2; outputs sampled 1 time unit after each rising edge.
module tb_seq_player;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  level;
    logic [31:0] seq_in;
    logic [3:0]  led;
    logic [3:0]  idx;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total    = 0;

    seq_player #(.ON_CYCLES(3), .OFF_CYCLES(2), .MAX_LEN(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .level  (level),
        .seq_in (seq_in),
        .led    (led),
        .idx    (idx),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // The tick inside is edge 0 of the playback.
    task automatic start_play(input logic [4:0] lvl, input logic [31:0] seq);
        level  = lvl;
        seq_in = seq;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    function automatic logic [3:0] onehot(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    initial begin
        logic [3:0] exp_led;
        int         k, ph, done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        level  = 5'd0;
        seq_in = 32'd0;
        #12;
        check("rst_led", 32'(led), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();

        // Level 2: entry0 = 2 -> 0100, entry1 = 1 -> 0010.
        start_play(5'd2, 32'h0000_0006);
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp_led = (e <= 3) ? 4'b0100 : (e >= 6 && e <= 8) ? 4'b0010 : 4'b0000;
            check($sformatf("l2_led_e%0d", e), 32'(led), 32'(exp_led));
            check($sformatf("l2_done_e%0d", e), 32'(done), (e == 10) ? 32'd1 : 32'd0);
            check($sformatf("l2_busy_e%0d", e), 32'(busy), (e <= 10) ? 32'd1 : 32'd0);
            check($sformatf("l2_idx_e%0d", e), 32'(idx), (e <= 5) ? 32'd0 : 32'd1);
        end
        tick();

        // Level 0: straight to DONE, no LEDs.
        start_play(5'd0, 32'hFFFF_FFFF);
        tick();
        check("l0_done_e1", 32'(done), 32'd1);
        check("l0_busy_e1", 32'(busy), 32'd1);
        check("l0_led_e1", 32'(led), 32'h0);
        tick();
        check("l0_done_e2", 32'(done), 32'd0);
        check("l0_busy_e2", 32'(busy), 32'd0);
        check("l0_led_e2", 32'(led), 32'h0);
        tick();

        // Level 20 clamps to 16; entries cycle 0,1,2,3.
        start_play(5'd20, 32'hE4E4_E4E4);
        done_seen = 0;
        for (int e = 1; e <= 82; e++) begin
            tick();
            k  = (e - 1) / 5;
            ph = (e - 1) % 5;
            exp_led = (e <= 80 && ph < 3) ? onehot(k % 4) : 4'b0000;
            check($sformatf("l20_led_e%0d", e), 32'(led), 32'(exp_led));
            if (done) done_seen++;
            if (e == 80) check("l20_done_e80", 32'(done), 32'd1);
            if (e == 76) check("l20_idx_e76", 32'(idx), 32'd15);
            if (e == 81) check("l20_busy_e81", 32'(busy), 32'd0);
        end
        check("l20_done_count", 32'(done_seen), 32'd1);

        // Latching: seq_in/level change and a start during ON have no effect.
        start_play(5'd2, 32'h0000_0006);
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 1) begin
                seq_in = 32'hFFFF_FFFF;
                level  = 5'd16;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            exp_led = (e <= 3) ? 4'b0100 : (e >= 6 && e <= 8) ? 4'b0010 : 4'b0000;
            check($sformatf("latch_led_e%0d", e), 32'(led), 32'(exp_led));
            check($sformatf("latch_done_e%0d", e), 32'(done), (e == 10) ? 32'd1 : 32'd0);
        end
        check("latch_busy_e11", 32'(busy), 32'd0);
        tick();

        // Abort in the OFF gap of entry 1, with a start alongside it.
        start_play(5'd3, 32'h0000_0006);
        for (int e = 1; e <= 8; e++) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        check("abort_led", 32'(led), 32'h0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        tick();
        start = 1'b0;
        check("abort_start_ignored", 32'(busy), 32'd0);
        tick();
        check("restart_led", 32'(led), 32'b0100);
        check("restart_idx", 32'(idx), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        for (int e = 0; e < 16; e++) begin
            tick();
            check($sformatf("restart_nodone_%0d", e), 32'(done), (e == 13) ? 32'd1 : 32'd0);
        end
        tick();

        // Asynchronous reset while entry 1 is lit.
        start_play(5'd2, 32'h0000_0006);
        for (int e = 1; e <= 6; e++) tick();
        check("pre_rst_led", 32'(led), 32'b0010);
        check("pre_rst_idx", 32'(idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_idx", 32'(idx), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_led", 32'(led), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
